// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_set codes and the bit-period divider table
// used by both the transmitter and the receiver (50 MHz clock).
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // Bit period is DR+1 clocks.
    localparam logic [12:0] BPS_9600_DR   = 13'd5207;
    localparam logic [12:0] BPS_19200_DR  = 13'd2603;
    localparam logic [12:0] BPS_38400_DR  = 13'd1301;
    localparam logic [12:0] BPS_57600_DR  = 13'd867;
    localparam logic [12:0] BPS_115200_DR = 13'd433;

    function automatic logic [12:0] baud_dr(input logic [2:0] baud_set);
        logic [12:0] dr;
        case (baud_set)
            BAUD_9600:   dr = BPS_9600_DR;
            BAUD_19200:  dr = BPS_19200_DR;
            BAUD_38400:  dr = BPS_38400_DR;
            BAUD_57600:  dr = BPS_57600_DR;
            BAUD_115200: dr = BPS_115200_DR;
            default:     dr = BPS_9600_DR;
        endcase
        return dr;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx pin into the clk domain and flags its
// high-to-low transitions with a registered one-cycle pulse.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic synced,
    output logic fall
);

    logic sync_1_r;
    logic sync_2_r;
    logic hist_r;
    logic fall_r;

    // Idle-high reset values so that no edge is seen when reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1_r <= 1'b1;
            sync_2_r <= 1'b1;
            hist_r   <= 1'b1;
            fall_r   <= 1'b0;
        end else begin
            sync_1_r <= rx;
            sync_2_r <= sync_1_r;
            hist_r   <= sync_2_r;
            fall_r   <= hist_r & ~sync_2_r;
        end
    end

    assign synced = sync_2_r;
    assign fall   = fall_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: finds the start edge, samples each bit at mid-period
// and reports each frame with an rx_done or frame_err strobe.
module uart_rx
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [2:0]           baud_set,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 uart_state
);

    localparam logic [0:0] IDLE_ENC = 1'b0;
    localparam logic [0:0] RECV_ENC = 1'b1;

    typedef enum logic [0:0] {
        IDLE = IDLE_ENC,
        RECV = RECV_ENC
    } state_t;

    state_t                 state_r,   state_nx;
    logic [12:0]            div_cnt_r, div_cnt_nx;
    logic [3:0]             bit_idx_r, bit_idx_nx;
    logic [12:0]            dr_r,      dr_nx;
    logic [DATA_BITS-1:0]   shift_r,   shift_nx;
    logic [DATA_BITS-1:0]   data_r,    data_nx;
    logic                   rx_done_r, rx_done_nx;
    logic                   frame_err_r, frame_err_nx;
    logic                   uart_state_r, uart_state_nx;
    logic                   synced_s;
    logic                   fall_s;
    logic                   mid_s;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx     (rx),
        .synced (synced_s),
        .fall   (fall_s)
    );

    assign mid_s = (div_cnt_r == (dr_r >> 1));

    // Next-state, bit timing, sampling and strobe generation.
    always_comb begin
        state_nx     = state_r;
        div_cnt_nx   = div_cnt_r;
        bit_idx_nx   = bit_idx_r;
        dr_nx        = dr_r;
        shift_nx     = shift_r;
        data_nx      = data_r;
        rx_done_nx   = 1'b0;
        frame_err_nx = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_nx   = RECV;
                    div_cnt_nx = 13'd0;
                    bit_idx_nx = 4'd0;
                    dr_nx      = baud_dr(baud_set);
                end else begin
                    state_nx = IDLE;
                end
            end
            RECV: begin
                if (div_cnt_r == dr_r) begin
                    div_cnt_nx = 13'd0;
                    bit_idx_nx = bit_idx_r + 4'd1;
                end else begin
                    div_cnt_nx = div_cnt_r + 13'd1;
                end
                if (mid_s) begin
                    case (bit_idx_r)
                        4'd0: begin
                            // A start bit that is high again at its midpoint was a glitch.
                            if (synced_s) begin
                                state_nx = IDLE;
                            end else begin
                                state_nx = RECV;
                            end
                        end
                        4'd9: begin
                            state_nx = IDLE;
                            if (synced_s) begin
                                data_nx    = shift_r;
                                rx_done_nx = 1'b1;
                            end else begin
                                frame_err_nx = 1'b1;
                            end
                        end
                        default: begin
                            if (bit_idx_r <= 4'd8) begin
                                shift_nx = {synced_s, shift_r[DATA_BITS-1:1]};
                            end else begin
                                state_nx = IDLE;
                            end
                        end
                    endcase
                end else begin
                    state_nx = RECV;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        uart_state_nx = (state_nx == RECV);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            div_cnt_r    <= 13'd0;
            bit_idx_r    <= 4'd0;
            dr_r         <= BPS_9600_DR;
            shift_r      <= {DATA_BITS{1'b0}};
            data_r       <= {DATA_BITS{1'b0}};
            rx_done_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            uart_state_r <= 1'b0;
        end else begin
            state_r      <= state_nx;
            div_cnt_r    <= div_cnt_nx;
            bit_idx_r    <= bit_idx_nx;
            dr_r         <= dr_nx;
            shift_r      <= shift_nx;
            data_r       <= data_nx;
            rx_done_r    <= rx_done_nx;
            frame_err_r  <= frame_err_nx;
            uart_state_r <= uart_state_nx;
        end
    end

    assign data       = data_r;
    assign rx_done    = rx_done_r;
    assign frame_err  = frame_err_r;
    assign uart_state = uart_state_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected strobes into a
// queue that an independent monitor pops whenever the receiver strobes.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [2:0] baud_set;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   run_len = 0;
    int   last_run = 0;
    logic prev_strobe = 1'b0;

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .baud_set   (baud_set),
        .data       (data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Monitor: pops the scoreboard on every strobe and tracks uart_state run lengths.
    always @(negedge clk) begin
        exp_t e;
        if (rx_done || frame_err) begin
            checks++;
            if (rx_done && frame_err) begin
                errors++;
                $display("FAIL strobe_exclusive actual both high required one");
            end
            checks++;
            if (prev_strobe) begin
                errors++;
                $display("FAIL strobe_width actual strobe two cycles in a row required one cycle");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe actual rx_done=%0b frame_err=%0b data=%02h required none",
                         rx_done, frame_err, data);
            end else begin
                e = exp_q.pop_front();
                if ((frame_err != e.err) || (data != e.data)) begin
                    errors++;
                    $display("FAIL strobe_value actual frame_err=%0b data=%02h required frame_err=%0b data=%02h",
                             frame_err, data, e.err, e.data);
                end
            end
        end
        prev_strobe = rx_done || frame_err;
        if (uart_state) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if ((act < lo) || (act > hi)) begin
            errors++;
            $display("FAIL %s actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s actual %0d strobes missing required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Drives one frame; chg_bit >= 0 rewrites baud_set at that bit position.
    task automatic send_frame(input logic [7:0] b, input int clks, input logic stop,
                              input int stop_clks, input int chg_bit, input logic [2:0] chg_val);
        for (int i = 0; i < 10; i++) begin
            if (i == chg_bit) baud_set = chg_val;
            if (i == 0)      rx = 1'b0;
            else if (i == 9) rx = stop;
            else             rx = b[i-1];
            repeat ((i == 9) ? stop_clks : clks) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    initial begin
        rx       = 1'b1;
        baud_set = 3'd0;
        rst_n    = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_rx_done", {31'd0, rx_done}, 32'h0);
        check("reset_frame_err", {31'd0, frame_err}, 32'h0);
        check("reset_uart_state", {31'd0, uart_state}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 0xA3 at 9600
        exp_q.push_back('{err: 1'b0, data: 8'hA3});
        send_frame(8'hA3, 5208, 1'b1, 10, -1, 3'd0);
        wait_drain("drain_9600", 4000);
        check("data_9600", {24'd0, data}, 32'hA3);

        // 100-clk glitch at 115200: false start, no strobe
        baud_set = 3'd4;
        repeat (20) @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_data", {24'd0, data}, 32'hA3);
        check("glitch_uart_state", {31'd0, uart_state}, 32'h0);
        check_range("glitch_busy_len", last_run, 215, 220);

        // 0x3C with stop low, then line held low (break)
        exp_q.push_back('{err: 1'b1, data: 8'hA3});
        send_frame(8'h3C, 434, 1'b0, 434 + 2 * 4340, -1, 3'd0);
        wait_drain("drain_frame_err", 10);
        check("frame_err_data", {24'd0, data}, 32'hA3);
        repeat (600) @(negedge clk);

        // reset during a byte
        rx = 1'b0;
        repeat (434) @(negedge clk);
        rx = 1'b1;
        repeat (434) @(negedge clk);
        rx = 1'b0;
        repeat (434) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        #2;
        check("midreset_data", {24'd0, data}, 32'h00);
        check("midreset_uart_state", {31'd0, uart_state}, 32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("after_reset_uart_state", {31'd0, uart_state}, 32'h0);

        // back-to-back at 57600, baud_set changed to 115200 inside the third frame
        baud_set = 3'd3;
        repeat (20) @(negedge clk);
        exp_q.push_back('{err: 1'b0, data: 8'h00});
        exp_q.push_back('{err: 1'b0, data: 8'hFF});
        exp_q.push_back('{err: 1'b0, data: 8'h81});
        send_frame(8'h00, 868, 1'b1, 868, -1, 3'd0);
        send_frame(8'hFF, 868, 1'b1, 868, -1, 3'd0);
        send_frame(8'h81, 868, 1'b1, 10, 4, 3'd4);
        wait_drain("drain_b2b", 2000);
        check("b2b_last_data", {24'd0, data}, 32'h81);

        // next frame uses the rate latched at its own start edge
        repeat (100) @(negedge clk);
        exp_q.push_back('{err: 1'b0, data: 8'h55});
        send_frame(8'h55, 434, 1'b1, 10, -1, 3'd0);
        wait_drain("drain_115200", 600);
        repeat (2) @(negedge clk);
        check("data_115200", {24'd0, data}, 32'h55);
        check_range("frame_busy_len", last_run, 4118, 4128);

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
